// File: rtl/l2_arbiter_pkg.sv
// Shared types for the L2 arbiter: FSM states, requester identities and the
// cache-line container.
package l2_arb_pkg;

    localparam int L2_ADDR_W = 32;
    localparam int L2_LINE_W = 256;

    typedef enum logic [1:0] {
        IDLE,
        SERVE_I,
        SERVE_D
    } arb_state_t;

    typedef enum logic {
        REQ_I,
        REQ_D
    } requester_t;

    typedef logic [L2_LINE_W-1:0] line_t;

endpackage

// File: rtl/l2_arbiter_if.sv
// Bundle of the L1-side miss streams and the L2 CPU-side port. The arbiter
// takes the master view; the L1 caches and L2 together form the slave view.
interface l2_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 256
);

    logic                  i_read;
    logic [ADDR_WIDTH-1:0] i_address;
    logic [LINE_WIDTH-1:0] i_rdata;
    logic                  i_resp;

    logic                  d_read;
    logic                  d_write;
    logic [ADDR_WIDTH-1:0] d_address;
    logic [LINE_WIDTH-1:0] d_wdata;
    logic [LINE_WIDTH-1:0] d_rdata;
    logic                  d_resp;

    logic                  l2_read;
    logic                  l2_write;
    logic [ADDR_WIDTH-1:0] l2_address;
    logic [LINE_WIDTH-1:0] l2_wdata;
    logic [LINE_WIDTH-1:0] l2_rdata;
    logic                  l2_resp;

    modport master (
        input  i_read, i_address,
        input  d_read, d_write, d_address, d_wdata,
        input  l2_rdata, l2_resp,
        output i_rdata, i_resp,
        output d_rdata, d_resp,
        output l2_read, l2_write, l2_address, l2_wdata
    );

    modport slave (
        output i_read, i_address,
        output d_read, d_write, d_address, d_wdata,
        output l2_rdata, l2_resp,
        input  i_rdata, i_resp,
        input  d_rdata, d_resp,
        input  l2_read, l2_write, l2_address, l2_wdata
    );

endinterface

// File: rtl/l2_arbiter_rr.sv
// Two-input round-robin picker. last_grant only moves when both streams
// contended, so an uncontested grant never costs the other stream its turn.
module rr_arbiter2
    import l2_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       req_i,
    input  logic       req_d,
    input  logic       grant_en,
    output logic       grant_valid,
    output requester_t grant_sel
);

    requester_t last_grant_q;
    requester_t last_grant_d;

    always_comb begin
        grant_valid  = req_i | req_d;
        grant_sel    = REQ_I;
        last_grant_d = last_grant_q;

        if (req_i && req_d) begin
            grant_sel = (last_grant_q == REQ_I) ? REQ_D : REQ_I;
            if (grant_en) begin
                last_grant_d = grant_sel;
            end
        end else if (req_d) begin
            grant_sel = REQ_D;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= REQ_I;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/l2_arbiter.sv
// Serialises I-cache and D-cache misses onto the single L2 port: grants one
// stream, holds its registered command until l2_resp, and routes the reply.
module l2_arbiter
    import l2_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 256
) (
    input logic          clk,
    input logic          rst,
    l2_arbiter_if.master bus
);

    arb_state_t            state_q, state_d;
    logic [ADDR_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
    logic [LINE_WIDTH-1:0] cmd_wdata_q, cmd_wdata_d;
    logic                  cmd_write_q, cmd_write_d;

    logic       req_d_any;
    logic       grant_en;
    logic       grant_valid;
    requester_t grant_sel;

    // A simultaneous d_read/d_write resolves to the write-back.
    assign req_d_any = bus.d_read | bus.d_write;

    rr_arbiter2 u_rr (
        .clk         (clk),
        .rst         (rst),
        .req_i       (bus.i_read),
        .req_d       (req_d_any),
        .grant_en    (grant_en),
        .grant_valid (grant_valid),
        .grant_sel   (grant_sel)
    );

    always_comb begin
        state_d     = state_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
        cmd_write_d = cmd_write_q;
        grant_en    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    grant_en = 1'b1;
                    if (grant_sel == REQ_D) begin
                        cmd_addr_d  = bus.d_address;
                        cmd_wdata_d = bus.d_wdata;
                        cmd_write_d = bus.d_write;
                        state_d     = SERVE_D;
                    end else begin
                        cmd_addr_d  = bus.i_address;
                        cmd_write_d = 1'b0;
                        state_d     = SERVE_I;
                    end
                end
            end
            SERVE_I, SERVE_D: begin
                if (bus.l2_resp) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            cmd_write_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_wdata_q <= cmd_wdata_d;
            cmd_write_q <= cmd_write_d;
        end
    end

    // Command comes only from the registers so it stays stable while the
    // requester is free to change its live inputs.
    assign bus.l2_read    = (state_q != IDLE) && !cmd_write_q;
    assign bus.l2_write   = (state_q != IDLE) &&  cmd_write_q;
    assign bus.l2_address = cmd_addr_q;
    assign bus.l2_wdata   = cmd_wdata_q;

    // A reset in the response cycle abandons the transaction, so no pulse.
    assign bus.i_resp  = (state_q == SERVE_I) && bus.l2_resp && !rst;
    assign bus.d_resp  = (state_q == SERVE_D) && bus.l2_resp && !rst;
    assign bus.i_rdata = bus.l2_rdata;
    assign bus.d_rdata = bus.l2_rdata;

endmodule

// File: doc/l2_arbiter.md
# l2_arbiter

Sequences access to the shared unified L2 cache for the two L1 miss streams: the instruction cache (read-only) and the data cache (read/write-back). The block sits between the L1 caches and the L2 cache's CPU-side port. It grants one requester at a time and registers that requester's command. It holds the command on the L2 port until the L2 responds, then routes the response back. Ties are broken round-robin so neither stream starves.

## Interface
- ADDR_WIDTH, 32, byte address width
- LINE_WIDTH, 256, cache-line width in bits
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- i_read  in  1  I-cache line read request
- i_address  in  ADDR_WIDTH  I-cache line address
- i_rdata  out  LINE_WIDTH  line returned to I-cache
- i_resp  out  1  one-cycle completion pulse to I-cache
- d_read  in  1  D-cache line read request
- d_write  in  1  D-cache line write-back request
- d_address  in  ADDR_WIDTH  D-cache line address
- d_wdata  in  LINE_WIDTH  write-back line
- d_rdata  out  LINE_WIDTH  line returned to D-cache
- d_resp  out  1  one-cycle completion pulse to D-cache
- l2_read  out  1  read command to L2
- l2_write  out  1  write command to L2
- l2_address  out  ADDR_WIDTH  registered command address
- l2_wdata  out  LINE_WIDTH  registered write data
- l2_rdata  in  LINE_WIDTH  L2 read data, valid with l2_resp
- l2_resp  in  1  L2 completion, may be combinational on a hit

## Operation
- States: IDLE, SERVE_I, SERVE_D.
- **IDLE**
  - No L2 command is driven.
  - If only one requester is active, grant it.
  - If both are active, grant the one not in last_grant; then update last_grant.
  - On grant, register the address, wdata (D only) and the op (read or write) into cmd registers, and go to SERVE_x.
  - If d_read and d_write are both high, the write wins. The bench flags this case as illegal.
- **SERVE_I / SERVE_D**
  - Drive l2_read or l2_write from the cmd register.
  - Drive l2_address and l2_wdata from the cmd registers, never from live inputs.
  - When l2_resp is high:
    - pulse the granted x_resp in the same cycle;
    - pass l2_rdata combinationally onto the granted x_rdata;
    - return to IDLE.
- Requesters hold their request stable until x_resp. They deassert in the cycle after x_resp.
- The ungranted requester simply waits. Its request is sampled again in the next IDLE cycle.
- i_rdata and d_rdata are driven from l2_rdata at all times. They are meaningful only while the matching x_resp is high.
- Reset values:
  - state = IDLE; last_grant = I, so the first tie goes to D;
  - cmd registers = 0;
  - all resp, read and write outputs = 0.
- A reset during SERVE_x abandons the transaction. The L2 command drops in the cycle after rst is sampled, and no x_resp is issued. The L2 is reset on the same rst.
- An l2_resp that arrives in IDLE is ignored.

## Timing
- Request first seen high in IDLE at cycle N: grant and register at the edge ending N; L2 command asserted from cycle N+1.
- An L2 hit that responds combinationally gives x_resp at N+1. This is the minimum latency of 2 cycles, request to resp.
- A miss or write-back gives x_resp in the same cycle as l2_resp, where that cycle is ≥ N+1.
- There is one idle cycle between back-to-back transactions. Best-case throughput is one transaction per 2 cycles.
- The L2 command stays stable from N+1 through the l2_resp cycle inclusive, and deasserts the following cycle.
- Worst-case wait for a contending requester is one full transaction of the other stream.

## Structure
- Shared package l2_arb_pkg holds:
  - typedef enum arb_state_t {IDLE, SERVE_I, SERVE_D};
  - typedef enum requester_t {REQ_I, REQ_D};
  - a line_t typedef of LINE_WIDTH bits.
- One natural sub-module, rr_arbiter2: a two-input round-robin picker.
  - Outputs: grant_valid and grant_sel.
  - Contains the last_grant register, which updates on a grant-enable input.
- The FSM and cmd registers stay in l2_arbiter.

## Test plan
- I-only read of 0x0000_1040, l2_resp the next cycle with data 0xAA…AA: l2_read high one cycle with l2_address 0x0000_1040; i_resp pulses once; i_rdata = 0xAA…AA; d_resp stays 0.
- D write-back to 0x0000_2000 with wdata 0x55…55, l2_resp after 10 cycles: l2_write held for 10 cycles with stable address and data; d_resp pulses once; no l2_read.
- i_read and d_read both high from reset: D is served first, then I after one IDLE cycle. A second simultaneous pair is served I first, then D.
- d_address changes mid-transaction from 0x100 to 0x200 before l2_resp: l2_address stays 0x100 throughout.
- rst asserted during SERVE_D: the next cycle shows l2_read = l2_write = 0 and state IDLE, with no d_resp. A tie afterwards grants D.
- Spurious l2_resp in IDLE with no requests: i_resp = d_resp = 0 and the state is unchanged.
